spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 170 +++++++++++++++++
 tb/tb_spi_controller.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: 16-bit frames {R/W, addr[6:0], data[7:0]}, MSB first.
// Define SPI_CONTROLLER_READ_EN to add rw/cipo/rd_data for register reads.
module spi_controller #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
`ifdef SPI_CONTROLLER_READ_EN
  input  logic       rw,
  input  logic       cipo,
  output logic [7:0] rd_data,
`endif
  output logic       ready,
  output logic       done,
  output logic       cs,
  output logic       sclk,
  output logic       copi
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [14:0] sr_q, sr_d;
  logic        cs_q, cs_d, sclk_q, sclk_d, copi_q, copi_d;
  logic        done_q, done_d, ready_q, ready_d;
  logic [15:0] frame;

`ifdef SPI_CONTROLLER_READ_EN
  logic       rw_q, rw_d;
  logic [7:0] rx_q, rx_d, rd_q, rd_d;

  // Reads send zeros in the data byte while the peripheral drives cipo.
  always_comb frame = {rw, addr, rw ? wdata : 8'h00};
`else
  always_comb frame = {1'b1, addr, wdata};
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;
    ready_d = ready_q;
`ifdef SPI_CONTROLLER_READ_EN
    rw_d = rw_q;
    rx_d = rx_q;
    rd_d = rd_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          sr_d    = frame[14:0];
          copi_d  = frame[15];
          cs_d    = 1'b0;
          ready_d = 1'b0;
          div_d   = '0;
          bit_d   = '0;
`ifdef SPI_CONTROLLER_READ_EN
          rw_d = rw;
          rx_d = '0;
`endif
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
`ifdef SPI_CONTROLLER_READ_EN
        if (sclk_q && div_q == '0 && bit_q[3]) rx_d = {rx_q[6:0], cipo};
`endif
        if (div_q != DIV_LAST) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit; zero fill leaves copi low after bit 0.
            sclk_d = 1'b0;
            copi_d = sr_q[14];
            sr_d   = {sr_q[13:0], 1'b0};
          end else if (bit_q == 4'd15) begin
            state_d = GAP;
            cs_d    = 1'b1;
            copi_d  = 1'b0;
            done_d  = 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
            rd_d = rw_q ? rd_q : rx_q;
`endif
          end else begin
            bit_d  = bit_q + 4'd1;
            sclk_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
      rw_q <= 1'b0;
      rx_q <= '0;
      rd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef SPI_CONTROLLER_READ_EN
      rw_q <= rw_d;
      rx_q <= rx_d;
      rd_q <= rd_d;
`endif
    end
  end

  assign cs    = cs_q;
  assign sclk  = sclk_q;
  assign copi  = copi_q;
  assign done  = done_q;
  assign ready = ready_q;
`ifdef SPI_CONTROLLER_READ_EN
  assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV=4/GAP=8 and CLK_DIV=2/GAP=3) checked
// every cycle against a frame-age timing model; directed cases pin the model with literals.
module tb_spi_controller;
  localparam int D0 = 4, G0 = 8, D1 = 2, G1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start [2];
  logic rw [2];
  logic cipo [2];
  logic [6:0] addr [2];
  logic [7:0] wdata [2];
  logic ready [2], done [2], cs [2], sclk [2], copi [2];
  logic [7:0] rd_data [2];

  int checks = 0, failures = 0;

  // model state: age = cycles since the accepting edge, 0 when idle
  int age [2];
  logic [15:0] fexp [2];
  logic isrd [2];
  logic [7:0] ret [2], rd_exp [2];
  int force_ret [2];

  // line monitor state
  logic pcs [2], psclk [2];
  int lowlen [2], hilen [2], rises [2], last_len [2], last_rises [2], last_hi [2], ndone [2];
  logic [15:0] cap [2];
  logic [15:0] frq0 [$];
  logic [15:0] frq1 [$];
  logic [7:0] pwm_duty_cycle;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .addr(addr[0]), .wdata(wdata[0]),
`ifdef SPI_CONTROLLER_READ_EN
    .rw(rw[0]), .cipo(cipo[0]), .rd_data(rd_data[0]),
`endif
    .ready(ready[0]), .done(done[0]), .cs(cs[0]), .sclk(sclk[0]), .copi(copi[0])
  );

  spi_controller #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .addr(addr[1]), .wdata(wdata[1]),
`ifdef SPI_CONTROLLER_READ_EN
    .rw(rw[1]), .cipo(cipo[1]), .rd_data(rd_data[1]),
`endif
    .ready(ready[1]), .done(done[1]), .cs(cs[1]), .sclk(sclk[1]), .copi(copi[1])
  );

`ifndef SPI_CONTROLLER_READ_EN
  assign rd_data[0] = 8'h00;
  assign rd_data[1] = 8'h00;
`endif

  function automatic int dv(int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int gv(int i);
    return (i == 0) ? G0 : G1;
  endfunction

  // expected {cs, sclk, copi, done, ready} for a frame that is a cycles old
  function automatic logic [4:0] exp_out(int a, int d, logic [15:0] f);
    int k, j, b;
    if (a == 0) return 5'b10001;
    if (a <= 33 * d) begin
      k = a - 1;
      if (k < d) return {2'b00, f[15], 2'b00};
      j = k - d;
      b = j / (2 * d);
      if ((j % (2 * d)) < d) return {2'b01, f[15 - b], 2'b00};
      if (b == 15) return 5'b00000;
      return {2'b00, f[14 - b], 2'b00};
    end
    return {3'b100, (a == 33 * d + 1), 1'b0};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        age[i] = 0;
        rd_exp[i] = 8'h00;
      end else if (age[i] == 0) begin
        if (start[i]) begin
          age[i] = 1;
`ifdef SPI_CONTROLLER_READ_EN
          isrd[i] = !rw[i];
`else
          isrd[i] = 1'b0;
`endif
          fexp[i] = {!isrd[i], addr[i], isrd[i] ? 8'h00 : wdata[i]};
          ret[i] = (force_ret[i] >= 0) ? 8'(force_ret[i]) : 8'($urandom);
        end
      end else begin
        age[i] = age[i] + 1;
        if (age[i] == 33 * dv(i) + 1 && isrd[i]) rd_exp[i] = ret[i];
        if (age[i] == 33 * dv(i) + gv(i) + 1) age[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int a, k, b;
      logic [4:0] e, got;
      a = rst ? age[i] : 0;
      e = exp_out(a, dv(i), fexp[i]);
      got = {cs[i], sclk[i], copi[i], done[i], ready[i]};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL cycle_dut%0d t=%0t age=%0d {cs,sclk,copi,done,ready} got=%b exp=%b",
                 i, $time, a, got, e);
      end
`ifdef SPI_CONTROLLER_READ_EN
      checks++;
      if (rd_data[i] !== (rst ? rd_exp[i] : 8'h00)) begin
        failures++;
        $display("FAIL rd_data_dut%0d t=%0t got=%h exp=%h", i, $time, rd_data[i], rd_exp[i]);
      end
`endif
      // peripheral: drive cipo with the return byte during data bits of a read
      cipo[i] = 1'b0;
      if (a >= 1 && a <= 33 * dv(i) && isrd[i]) begin
        k = a - 1;
        if (k >= dv(i)) begin
          b = (k - dv(i)) / (2 * dv(i));
          if (b >= 8) cipo[i] = ret[i][15 - b];
        end
      end
      // line monitor
      if (!cs[i] && pcs[i]) begin
        last_hi[i] = hilen[i];
        lowlen[i] = 0;
        rises[i] = 0;
        cap[i] = '0;
      end
      if (cs[i]) hilen[i] = pcs[i] ? hilen[i] + 1 : 1;
      else lowlen[i] = lowlen[i] + 1;
      if (!cs[i] && sclk[i] && !psclk[i]) begin
        cap[i] = {cap[i][14:0], copi[i]};
        rises[i] = rises[i] + 1;
      end
      if (cs[i] && !pcs[i]) begin
        last_len[i] = lowlen[i];
        last_rises[i] = rises[i];
        if (i == 0) begin
          frq0.push_back(cap[i]);
          if (cap[i][15] && cap[i][14:8] == 7'h04) pwm_duty_cycle = cap[i][7:0];
        end else begin
          frq1.push_back(cap[i]);
        end
      end
      if (done[i]) ndone[i] = ndone[i] + 1;
      pcs[i] = cs[i];
      psclk[i] = sclk[i];
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input string nm);
    int n = 0;
    while (!done[i] && n < 1000) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, {31'd0, done[i]}, 32'd1);
  endtask

  task automatic wait_ready(input int i, input string nm);
    int n = 0;
    while (!ready[i] && n < 1000) begin
      tick();
      n++;
    end
    check({nm, "_ready_seen"}, {31'd0, ready[i]}, 32'd1);
  endtask

  function automatic logic [15:0] pop0();
    if (frq0.size() == 0) return 16'hxxxx;
    return frq0.pop_front();
  endfunction

  function automatic logic [15:0] pop1();
    if (frq1.size() == 0) return 16'hxxxx;
    return frq1.pop_front();
  endfunction

  initial begin
    int nd, cnt;
    logic ps;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; rw[i] = 1'b1; addr[i] = '0; wdata[i] = '0;
      age[i] = 0; fexp[i] = '0; isrd[i] = 1'b0; ret[i] = '0; rd_exp[i] = '0; force_ret[i] = -1;
      pcs[i] = 1'b1; psclk[i] = 1'b0; lowlen[i] = 0; hilen[i] = 0; rises[i] = 0;
      last_len[i] = 0; last_rises[i] = 0; last_hi[i] = 0; ndone[i] = 0; cap[i] = '0;
    end
    pwm_duty_cycle = 8'h00;
    repeat (3) tick();
    check("reset_cs", {31'd0, cs[0]}, 32'd1);
    check("reset_sclk_copi_done", {29'd0, sclk[0], copi[0], done[0]}, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_ready", {31'd0, ready[0]}, 32'd1);

    // single write frame on both instances
    frq0.delete(); frq1.delete(); nd = ndone[0];
    addr[0] = 7'h04; wdata[0] = 8'h80; start[0] = 1'b1;
    addr[1] = 7'h0A; wdata[1] = 8'h55; start[1] = 1'b1;
    tick();
    start[0] = 1'b0; start[1] = 1'b0;
    addr[0] = 7'h7F; wdata[0] = 8'h00;
    check("accept_cs_low", {31'd0, cs[0]}, 32'd0);
    wait_done(0, "f29");
    tick();
    check("f29_frame", {16'd0, pop0()}, 32'h8480);
    check("f29_cs_low", last_len[0], 32'd132);
    check("f29_rises", last_rises[0], 32'd16);
    check("f29_done_cnt", ndone[0] - nd, 32'd1);
    check("f29_pwm", {24'd0, pwm_duty_cycle}, 32'h80);
    check("div2_frame", {16'd0, pop1()}, 32'h8A55);
    check("div2_cs_low", last_len[1], 32'd66);
    check("div2_rises", last_rises[1], 32'd16);

    // start held high: back-to-back frames
    wait_ready(0, "b2b0");
    frq0.delete(); nd = ndone[0];
    addr[0] = 7'h00; wdata[0] = 8'hFF; start[0] = 1'b1;
    tick();
    addr[0] = 7'h01; wdata[0] = 8'h0F;
    wait_ready(0, "b2b1");
    tick();
    start[0] = 1'b0;
    wait_done(0, "b2b");
    tick();
    check("b2b_frame1", {16'd0, pop0()}, 32'h80FF);
    check("b2b_frame2", {16'd0, pop0()}, 32'h810F);
    check("b2b_cs_high", last_hi[0], G0 + 1);
    check("b2b_done_cnt", ndone[0] - nd, 32'd2);

    // start pulse during SHIFT is ignored
    wait_ready(0, "ign");
    frq0.delete(); nd = ndone[0];
    addr[0] = 7'h11; wdata[0] = 8'h22; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (40) tick();
    addr[0] = 7'h7F; wdata[0] = 8'hFF; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, "ign");
    repeat (G0 + 4) tick();
    check("ign_frame", {16'd0, pop0()}, 32'h9122);
    check("ign_frame_count", frq0.size(), 32'd0);
    check("ign_done_cnt", ndone[0] - nd, 32'd1);

    // asynchronous reset at the 7th sclk rise
    wait_ready(0, "rst");
    addr[0] = 7'h55; wdata[0] = 8'hAA; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cnt = 0; ps = 1'b0;
    for (int n = 0; n < 300 && cnt < 7; n++) begin
      tick();
      if (sclk[0] && !ps) cnt++;
      ps = sclk[0];
    end
    check("rst_rise_seen", cnt, 32'd7);
    nd = ndone[0];
    rst = 1'b0;
    #1;
    check("rst_async_cs", {31'd0, cs[0]}, 32'd1);
    check("rst_async_sclk", {31'd0, sclk[0]}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_no_done", ndone[0] - nd, 32'd0);
    check("rst_ready", {31'd0, ready[0]}, 32'd1);
    frq0.delete();
    addr[0] = 7'h02; wdata[0] = 8'h3C; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, "rst");
    tick();
    check("rst_next_frame", {16'd0, pop0()}, 32'h823C);

`ifdef SPI_CONTROLLER_READ_EN
    wait_ready(0, "rd");
    frq0.delete(); force_ret[0] = 8'hA5;
    rw[0] = 1'b0; addr[0] = 7'h03; wdata[0] = 8'h77; start[0] = 1'b1;
    tick();
    start[0] = 1'b0; rw[0] = 1'b1;
    wait_done(0, "rd");
    check("rd_data_at_done", {24'd0, rd_data[0]}, 32'hA5);
    tick();
    check("rd_frame", {16'd0, pop0()}, 32'h0300);
    force_ret[0] = -1;
`endif

    // randomized traffic on both instances
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        addr[i] = 7'($urandom);
        wdata[i] = 8'($urandom);
        rw[i] = 1'($urandom);
      end
      tick();
    end
    start[0] = 1'b0; start[1] = 1'b0;
    wait_ready(0, "end0");
    wait_ready(1, "end1");
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
